// File: rtl/ga_video_decoder_pkg.sv
// Shared constants and the colour-pin decode helper for the gate array video decoder.
package ga_video_pkg;

    localparam int HCNT_W = 10;
    localparam int VCNT_W = 9;

    localparam logic [7:0] LVL_OFF        = 8'h00;
    localparam logic [7:0] LVL_FULL       = 8'hFF;
    localparam logic [7:0] DEF_HALF_LEVEL = 8'h80;

    localparam logic [HCNT_W-1:0] HCNT_MAX = '1;
    localparam logic [VCNT_W-1:0] VCNT_MAX = '1;

    // An undriven pin floats to the resistor midpoint, so the pin value is ignored.
    function automatic logic [7:0] decode_pin(input logic pin, input logic oe_n,
                                              input logic [7:0] half);
        if (oe_n) return half;
        return pin ? LVL_FULL : LVL_OFF;
    endfunction

endpackage

// File: rtl/ga_video_decoder_if.sv
// Gate array pin bundle in, decoded video stream out; master is the gate array side.
interface ga_video_decoder_if;

    logic                          cen_16;
    logic                          HSYNC;
    logic                          VSYNC;
    logic                          RED;
    logic                          GREEN;
    logic                          BLUE;
    logic                          RED_OE_N;
    logic                          GREEN_OE_N;
    logic                          BLUE_OE_N;

    logic [7:0]                    R_O;
    logic [7:0]                    G_O;
    logic [7:0]                    B_O;
    logic                          HS_O;
    logic                          VS_O;
    logic                          HBLANK;
    logic                          VBLANK;
    logic                          CE_PIX;
    logic [ga_video_pkg::HCNT_W-1:0] HCNT;
    logic [ga_video_pkg::VCNT_W-1:0] VCNT;
    logic [ga_video_pkg::HCNT_W-1:0] LINE_LEN;

    // No backpressure: every output is a new pixel on the clk where CE_PIX=1,
    // and the sink must take it then.
    modport master (
        output cen_16, HSYNC, VSYNC, RED, GREEN, BLUE, RED_OE_N, GREEN_OE_N, BLUE_OE_N,
        input  R_O, G_O, B_O, HS_O, VS_O, HBLANK, VBLANK, CE_PIX, HCNT, VCNT, LINE_LEN
    );

    modport slave (
        input  cen_16, HSYNC, VSYNC, RED, GREEN, BLUE, RED_OE_N, GREEN_OE_N, BLUE_OE_N,
        output R_O, G_O, B_O, HS_O, VS_O, HBLANK, VBLANK, CE_PIX, HCNT, VCNT, LINE_LEN
    );

endinterface

// File: rtl/ga_video_decoder_sync_counter.sv
// Sync edge detection, beam counters, line-length capture and blanking flags.
module ga_sync_counter
    import ga_video_pkg::*;
#(
    parameter int HBL_END   = 208,
    parameter int HBL_START = 976,
    parameter int VBL_END   = 24,
    parameter int VBL_START = 296
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cen,
    input  logic              hs,
    input  logic              vs,
    output logic [HCNT_W-1:0] hcnt,
    output logic [VCNT_W-1:0] vcnt,
    output logic [HCNT_W-1:0] line_len,
    output logic              hblank,
    output logic              vblank,
    output logic              blank_nxt
);

    logic              hs_hist;
    logic              vs_hist;
    logic              primed;
    logic              hs_rise;
    logic              vs_rise;
    logic [HCNT_W-1:0] hcnt_nxt;
    logic [VCNT_W-1:0] vcnt_nxt;
    logic              hblank_nxt;
    logic              vblank_nxt;

    always_comb begin
        hs_rise = hs & ~hs_hist;
        vs_rise = vs & ~vs_hist;

        hcnt_nxt = hcnt;
        if (hs_rise)               hcnt_nxt = '0;
        else if (hcnt != HCNT_MAX) hcnt_nxt = hcnt + HCNT_W'(1);

        // A VSYNC rise on the same tick as an HSYNC rise still leaves vcnt at 0.
        vcnt_nxt = vcnt;
        if (vs_rise)                          vcnt_nxt = '0;
        else if (hs_rise && vcnt != VCNT_MAX) vcnt_nxt = vcnt + VCNT_W'(1);

        hblank_nxt = (int'(hcnt_nxt) < HBL_END) || (int'(hcnt_nxt) >= HBL_START);
        vblank_nxt = (int'(vcnt_nxt) < VBL_END) || (int'(vcnt_nxt) >= VBL_START);
        blank_nxt  = hblank_nxt | vblank_nxt;
    end

    // Until the first tick after reset the stage-1 syncs hold reset values, so the
    // history is pinned high for that tick to keep a sync already high from counting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hs_hist  <= 1'b1;
            vs_hist  <= 1'b1;
            primed   <= 1'b0;
            hcnt     <= '0;
            vcnt     <= '0;
            line_len <= '0;
            hblank   <= 1'b1;
            vblank   <= 1'b1;
        end else if (cen) begin
            hs_hist <= hs | ~primed;
            vs_hist <= vs | ~primed;
            primed  <= 1'b1;
            if (hs_rise) line_len <= hcnt;
            hcnt    <= hcnt_nxt;
            vcnt    <= vcnt_nxt;
            hblank  <= hblank_nxt;
            vblank  <= vblank_nxt;
        end
    end

endmodule

// File: rtl/ga_video_decoder.sv
// Decodes the gate array's tri-level colour pins into registered 8-bit RGB with
// sync, blanking and beam counters, two cen_16 ticks behind the pins.
module ga_video_decoder
    import ga_video_pkg::*;
#(
    parameter logic [7:0] HALF_LEVEL = DEF_HALF_LEVEL,
    parameter int         HBL_END    = 208,
    parameter int         HBL_START  = 976,
    parameter int         VBL_END    = 24,
    parameter int         VBL_START  = 296
) (
    input  logic               clk,
    input  logic               RESET_N,
    ga_video_decoder_if.slave  vid
);

    logic       s1_hs;
    logic       s1_vs;
    logic [2:0] s1_pin;
    logic [2:0] s1_oe_n;
    logic       blank_nxt;

    always_ff @(posedge clk) begin
        if (!RESET_N) begin
            s1_hs   <= 1'b0;
            s1_vs   <= 1'b0;
            s1_pin  <= '0;
            s1_oe_n <= '1;
        end else if (vid.cen_16) begin
            s1_hs   <= vid.HSYNC;
            s1_vs   <= vid.VSYNC;
            s1_pin  <= {vid.BLUE, vid.GREEN, vid.RED};
            s1_oe_n <= {vid.BLUE_OE_N, vid.GREEN_OE_N, vid.RED_OE_N};
        end
    end

    ga_sync_counter #(
        .HBL_END   (HBL_END),
        .HBL_START (HBL_START),
        .VBL_END   (VBL_END),
        .VBL_START (VBL_START)
    ) u_sync_counter (
        .clk       (clk),
        .rst_n     (RESET_N),
        .cen       (vid.cen_16),
        .hs        (s1_hs),
        .vs        (s1_vs),
        .hcnt      (vid.HCNT),
        .vcnt      (vid.VCNT),
        .line_len  (vid.LINE_LEN),
        .hblank    (vid.HBLANK),
        .vblank    (vid.VBLANK),
        .blank_nxt (blank_nxt)
    );

    // Colour is gated by the blank value registered alongside it, so RGB is 0
    // exactly when the HBLANK/VBLANK outputs are high.
    always_ff @(posedge clk) begin
        if (!RESET_N) begin
            vid.R_O  <= LVL_OFF;
            vid.G_O  <= LVL_OFF;
            vid.B_O  <= LVL_OFF;
            vid.HS_O <= 1'b0;
            vid.VS_O <= 1'b0;
        end else if (vid.cen_16) begin
            vid.R_O  <= blank_nxt ? LVL_OFF : decode_pin(s1_pin[0], s1_oe_n[0], HALF_LEVEL);
            vid.G_O  <= blank_nxt ? LVL_OFF : decode_pin(s1_pin[1], s1_oe_n[1], HALF_LEVEL);
            vid.B_O  <= blank_nxt ? LVL_OFF : decode_pin(s1_pin[2], s1_oe_n[2], HALF_LEVEL);
            vid.HS_O <= s1_hs;
            vid.VS_O <= s1_vs;
        end
    end

    always_ff @(posedge clk) begin
        if (!RESET_N) vid.CE_PIX <= 1'b0;
        else          vid.CE_PIX <= vid.cen_16;
    end

endmodule

// File: tb/tb_ga_video_decoder.sv
// Self-checking bench for ga_video_decoder against a sample-history reference model.
module tb_ga_video_decoder;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic [2:0] pin;
        logic [2:0] oen;
    } samp_t;

    typedef struct {
        logic       pin;
        logic       oen;
        logic [7:0] exp;
    } cvec_t;

    logic clk = 1'b0;
    logic RESET_N = 1'b0;
    always #5 clk = ~clk;

    ga_video_decoder_if vid();

    ga_video_decoder dut (
        .clk     (clk),
        .RESET_N (RESET_N),
        .vid     (vid)
    );

    int checks = 0;
    int errors = 0;

    samp_t hist_q[$];
    int    m_h, m_v, m_ll, m_r, m_g, m_b;
    bit    m_hbl, m_vbl, m_hs, m_vs, m_ce;
    int    idle_max = 2;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int lvl(input bit pin, input bit oen);
        if (oen) return 8'h80;
        return pin ? 8'hFF : 8'h00;
    endfunction

    function automatic samp_t rnd_samp(input bit hs, input bit vs);
        samp_t s;
        s.hs  = hs;
        s.vs  = vs;
        s.pin = 3'($urandom);
        s.oen = 3'($urandom);
        return s;
    endfunction

    task automatic model_reset();
        hist_q.delete();
        m_h = 0; m_v = 0; m_ll = 0;
        m_r = 0; m_g = 0; m_b = 0;
        m_hbl = 1; m_vbl = 1; m_hs = 0; m_vs = 0; m_ce = 0;
    endtask

    // Outputs after tick n reflect the sample taken at tick n-1; an edge needs two
    // samples taken since reset, so a sync high at release is never an edge.
    task automatic model_tick(input samp_t s);
        samp_t o;
        int    n;
        bit    hr, vr;
        hist_q.push_back(s);
        n = hist_q.size();
        o = '0;
        o.oen = '1;
        if (n >= 2) o = hist_q[n-2];
        hr = (n >= 3) && hist_q[n-2].hs && !hist_q[n-3].hs;
        vr = (n >= 3) && hist_q[n-2].vs && !hist_q[n-3].vs;
        if (hr) begin
            m_ll = m_h;
            m_h  = 0;
        end else if (m_h < 1023) begin
            m_h++;
        end
        if (vr)                 m_v = 0;
        else if (hr && m_v < 511) m_v++;
        m_hbl = (m_h < 208) || (m_h >= 976);
        m_vbl = (m_v < 24) || (m_v >= 296);
        m_hs = o.hs;
        m_vs = o.vs;
        if (m_hbl || m_vbl) begin
            m_r = 0; m_g = 0; m_b = 0;
        end else begin
            m_r = lvl(o.pin[0], o.oen[0]);
            m_g = lvl(o.pin[1], o.oen[1]);
            m_b = lvl(o.pin[2], o.oen[2]);
        end
    endtask

    task automatic check_outs();
        chk("r_o",      vid.R_O,      m_r);
        chk("g_o",      vid.G_O,      m_g);
        chk("b_o",      vid.B_O,      m_b);
        chk("hs_o",     vid.HS_O,     m_hs);
        chk("vs_o",     vid.VS_O,     m_vs);
        chk("hblank",   vid.HBLANK,   m_hbl);
        chk("vblank",   vid.VBLANK,   m_vbl);
        chk("hcnt",     vid.HCNT,     m_h);
        chk("vcnt",     vid.VCNT,     m_v);
        chk("line_len", vid.LINE_LEN, m_ll);
        chk("ce_pix",   vid.CE_PIX,   m_ce);
    endtask

    task automatic drive(input samp_t s);
        vid.HSYNC      = s.hs;
        vid.VSYNC      = s.vs;
        vid.RED        = s.pin[0];
        vid.GREEN      = s.pin[1];
        vid.BLUE       = s.pin[2];
        vid.RED_OE_N   = s.oen[0];
        vid.GREEN_OE_N = s.oen[1];
        vid.BLUE_OE_N  = s.oen[2];
    endtask

    task automatic tick(input samp_t s);
        int idle;
        drive(s);
        vid.cen_16 = 1'b1;
        @(posedge clk);
        #1;
        vid.cen_16 = 1'b0;
        model_tick(s);
        m_ce = 1;
        check_outs();
        idle = $urandom_range(0, idle_max);
        repeat (idle) begin
            @(posedge clk);
            #1;
            m_ce = 0;
            check_outs();
        end
    endtask

    task automatic hline(input int period);
        tick(rnd_samp(1'b1, 1'b0));
        repeat (period - 1) tick(rnd_samp(1'b0, 1'b0));
    endtask

    task automatic do_reset(input bit hs_level);
        RESET_N   = 1'b0;
        vid.HSYNC = hs_level;
        repeat (3) begin
            vid.cen_16 = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            model_reset();
            check_outs();
            chk("rst_line_len", vid.LINE_LEN, 0);
        end
        RESET_N    = 1'b1;
        vid.cen_16 = 1'b0;
    endtask

    cvec_t cv[8];
    samp_t s;

    initial begin
        cv[0] = '{pin: 1'b1, oen: 1'b0, exp: 8'hFF};
        cv[1] = '{pin: 1'b0, oen: 1'b0, exp: 8'h00};
        cv[2] = '{pin: 1'b1, oen: 1'b1, exp: 8'h80};
        cv[3] = '{pin: 1'b0, oen: 1'b1, exp: 8'h80};
        cv[4] = '{pin: 1'b1, oen: 1'b0, exp: 8'hFF};
        cv[5] = '{pin: 1'b0, oen: 1'b1, exp: 8'h80};
        cv[6] = '{pin: 1'b0, oen: 1'b0, exp: 8'h00};
        cv[7] = '{pin: 1'b1, oen: 1'b0, exp: 8'hFF};

        vid.cen_16 = 1'b0;
        drive('0);
        model_reset();

        // Reset with HSYNC held high: no edge until a real 0->1.
        do_reset(1'b1);
        for (int i = 0; i < 5; i++) begin
            tick(rnd_samp(1'b1, 1'b0));
            chk("hold_hi_hcnt", vid.HCNT, i + 1);
            chk("hold_hi_len", vid.LINE_LEN, 0);
        end
        tick(rnd_samp(1'b0, 1'b0));
        tick(rnd_samp(1'b1, 1'b0));
        tick(rnd_samp(1'b0, 1'b0));
        chk("first_edge_len", vid.LINE_LEN, 7);
        chk("first_edge_hcnt", vid.HCNT, 0);

        // Line length measurement.
        hline(1024);
        hline(1024);
        chk("len_1024", vid.LINE_LEN, 1023);
        hline(900);
        hline(4);
        chk("len_900", vid.LINE_LEN, 899);

        // Missing sync: saturate, no wrap.
        hline(2000);
        chk("sat_hcnt", vid.HCNT, 1023);
        chk("sat_hblank", vid.HBLANK, 1);
        hline(4);
        chk("sat_len", vid.LINE_LEN, 1023);

        // Colour decode table in the visible area.
        tick(rnd_samp(1'b0, 1'b1));
        repeat (100) hline(4);
        hline(500);
        chk("pos_vcnt", vid.VCNT, 101);
        for (int i = 0; i < 8; i++) begin
            s = rnd_samp(1'b0, 1'b0);
            s.pin = {3{cv[i].pin}};
            s.oen = {3{cv[i].oen}};
            tick(s);
            if (i > 0) begin
                chk("tbl_r", vid.R_O, cv[i-1].exp);
                chk("tbl_g", vid.G_O, cv[i-1].exp);
                chk("tbl_b", vid.B_O, cv[i-1].exp);
            end
        end
        tick(rnd_samp(1'b0, 1'b0));
        chk("tbl_r_last", vid.R_O, cv[7].exp);

        // Vertical saturation.
        repeat (420) hline(4);
        chk("vsat", vid.VCNT, 511);

        // Simultaneous HSYNC/VSYNC rise at vcnt 311.
        idle_max = 0;
        tick(rnd_samp(1'b0, 1'b1));
        repeat (311) hline(4);
        idle_max = 2;
        chk("pre_simul_vcnt", vid.VCNT, 311);
        tick(rnd_samp(1'b1, 1'b1));
        tick(rnd_samp(1'b0, 1'b0));
        chk("simul_vcnt", vid.VCNT, 0);
        chk("simul_hcnt", vid.HCNT, 0);
        chk("simul_vblank", vid.VBLANK, 1);

        // cen_16 held low while pins toggle.
        repeat (50) begin
            drive(rnd_samp(1'($urandom), 1'($urandom)));
            @(posedge clk);
            #1;
            m_ce = 0;
            check_outs();
        end

        // Reset mid-line.
        repeat (10) tick(rnd_samp(1'b0, 1'b0));
        do_reset(1'b0);
        tick(rnd_samp(1'b0, 1'b0));
        hline(20);
        hline(4);
        chk("midrst_len", vid.LINE_LEN, 19);

        // Randomised run with an asynchronous-looking sync pattern and one reset.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset(1'($urandom));
            tick(rnd_samp($urandom_range(0, 99) < 4, $urandom_range(0, 999) < 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ga_video_decoder.md
Name: ga_video_decoder

Overview:
- Sits directly downstream of the 40010 gate array.
- Consumes the gate array's tri-level colour pins (RED/GREEN/BLUE with their OE_N), HSYNC_O and VSYNC_O on the 16 MHz clock enable.
- Produces a registered 8-bit-per-channel digital RGB stream with sync, blanking and beam counters for the scaler/video mixer.
- Also measures line length so software-generated sync anomalies are observable.

Parameters:
- HALF_LEVEL, 8'h80, channel value when the pin is undriven (OE_N=1, resistor midpoint).
- HBL_END, 208, hcnt value at which horizontal blanking ends.
- HBL_START, 976, hcnt value at which horizontal blanking starts.
- VBL_END, 24, vcnt value at which vertical blanking ends.
- VBL_START, 296, vcnt value at which vertical blanking starts.

Ports:
- clk  in  1  system clock
- RESET_N  in  1  synchronous reset, active low
- cen_16  in  1  16 MHz clock enable, one clk wide
- HSYNC  in  1  gate array HSYNC_O
- VSYNC  in  1  gate array VSYNC_O
- RED, GREEN, BLUE  in  1 each  colour pin levels
- RED_OE_N, GREEN_OE_N, BLUE_OE_N  in  1 each  colour pin drive enables, active low
- R_O, G_O, B_O  out  8 each  decoded channel values
- HS_O, VS_O  out  1 each  delayed sync, aligned with RGB
- HBLANK, VBLANK  out  1 each  blanking flags, aligned with RGB
- CE_PIX  out  1  qualifies outputs; cen_16 delayed by one clk
- HCNT  out  10  ticks since last HSYNC rise
- VCNT  out  9  lines since last VSYNC rise
- LINE_LEN  out  10  hcnt value captured at the last HSYNC rise

Behaviour:
- All state updates only on clk edges where cen_16=1, except CE_PIX, which follows cen_16 every clk.
- Reset (RESET_N=0 at a clk edge, regardless of cen_16):
  - R_O/G_O/B_O=0, HS_O=VS_O=0, HBLANK=VBLANK=1, CE_PIX=0.
  - HCNT=VCNT=LINE_LEN=0.
  - Edge-detector history registers set to 1, so a sync already high at reset release does not count as a rising edge.
- Stage 1, on cen_16: register all eight inputs.
- Stage 2, on cen_16: decode each channel and register it with stage-1 syncs and blanking.
  - OE_N=0 and pin=1 -> 8'hFF.
  - OE_N=0 and pin=0 -> 8'h00.
  - OE_N=1 -> HALF_LEVEL, pin ignored.
  - Latency input->output is exactly 2 cen_16 ticks for colour, sync and blank alike.
- Blanking:
  - HBLANK = (hcnt < HBL_END) | (hcnt >= HBL_START).
  - VBLANK = (vcnt < VBL_END) | (vcnt >= VBL_START).
  - While HBLANK|VBLANK, R_O/G_O/B_O are forced to 0; HS_O/VS_O are unaffected.
- Horizontal counter (rising edge = stage-1 HSYNC high, history low):
  - On HSYNC rise: LINE_LEN <= hcnt, hcnt <= 0.
  - Else hcnt increments, saturating at 1023; no wrap.
- Vertical counter:
  - On HSYNC rise: vcnt increments, saturating at 511.
  - On VSYNC rise: vcnt <= 0.
  - If VSYNC and HSYNC rise on the same tick, VSYNC wins (vcnt=0) and hcnt also resets to 0.
- Reset mid-line: counters restart at 0. The first HSYNC rise after a low is seen then captures LINE_LEN normally.
- Counter values are exposed with the same 2-tick alignment as RGB.

Decomposition:
- Package ga_video_pkg: level constants LVL_OFF=8'h00, LVL_FULL=8'hFF, default HALF_LEVEL; counter widths HCNT_W=10, VCNT_W=9; saturation limits.
- One sub-module, ga_sync_counter: edge detection, hcnt/vcnt/LINE_LEN and blank flags. Instantiated once.
- Colour decode stays inline.

Test Plan:
- Colour decode: hold cen_16 periodic. Drive OE_N=0/RED=1, then OE_N=0/RED=0, then OE_N=1/RED=1, with hcnt=500 and vcnt=100 (unblanked) -> R_O = FF, 00, 80, each appearing exactly 2 cen_16 ticks after the input.
- Line measurement: HSYNC rise every 1024 ticks, then one line of 900 ticks -> LINE_LEN = 1023, then 899. HBLANK high for hcnt 0..207 and 976..1023, low between; RGB reads 0 while blanked.
- Missing sync: no HSYNC for 2000 ticks -> HCNT saturates at 1023, HBLANK stays 1, no wrap. The next HSYNC rise gives LINE_LEN=1023.
- Simultaneous edges: HSYNC and VSYNC rise on the same tick at vcnt=311 -> VCNT=0 and HCNT=0 two ticks later, VBLANK=1.
- Reset with HSYNC held high: assert RESET_N=0 for 3 clk, release with HSYNC=1 -> outputs 0 and blanks 1 during reset, LINE_LEN stays 0. The first counted edge is the next real 0->1 transition.
- cen_16 gating: hold cen_16=0 for 50 clk while inputs toggle -> no output or counter change, CE_PIX=0 throughout.
